io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_arbiter_if.sv | 47 ++++
 rtl/io_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Bus bundle for io_bus_arbiter: two requesting masters (m0, m1), the shared
// slave bus (io_*) and the sticky timeout status flag.
// Modport "slave" is the arbiter's view (it serves the bus masters' requests
// and drives the shared slave bus); modport "master" is the view of the
// surrounding system that drives master requests and slave responses.
interface io_bus_arbiter_if;
  logic [19:0] m0_address;
  logic        m0_read;
  logic        m0_write;
  logic [7:0]  m0_wdata;
  logic        m0_ack;
  logic [7:0]  m0_rdata;

  logic [19:0] m1_address;
  logic        m1_read;
  logic        m1_write;
  logic [7:0]  m1_wdata;
  logic        m1_ack;
  logic [7:0]  m1_rdata;

  logic [19:0] io_address;
  logic        io_read;
  logic        io_write;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;

  logic        timeout_err;

  modport slave (
    input  m0_address, m0_read, m0_write, m0_wdata,
    input  m1_address, m1_read, m1_write, m1_wdata,
    input  io_rdata, io_ack,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output io_address, io_read, io_write, io_wdata,
    output timeout_err
  );

  modport master (
    output m0_address, m0_read, m0_write, m0_wdata,
    output m1_address, m1_read, m1_write, m1_wdata,
    output io_rdata, io_ack,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  io_address, io_read, io_write, io_wdata,
    input  timeout_err
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master, one-slave 8-bit IO bus arbiter.
// Each master may have one request outstanding; requests are captured into a
// per-master pending entry and issued to the slave one at a time, with
// round-robin selection when both masters are waiting.
// Optional feature: define IO_ARB_TIMEOUT_EN to enable the slave-ack watchdog
// (TIMEOUT_CYCLES cycles in WAIT -> forced ack with 0xFF, sticky timeout_err).
// Without the macro WAIT lasts until io_ack and timeout_err is constant 0.
module io_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset,
  io_bus_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("io_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_r;

  // Pending entries, one per master; an entry stays set while in service.
  logic [1:0]  pend_r;
  logic [19:0] pend_addr_r  [2];
  logic [7:0]  pend_wdata_r [2];
  logic [1:0]  pend_write_r;

  logic        grant_r;
  logic        last_r;

  logic        io_read_r;
  logic        io_write_r;
  logic [19:0] io_address_r;
  logic [7:0]  io_wdata_r;
  logic [1:0]  ack_r;
  logic [7:0]  rdata_r [2];

  logic [1:0]  req_s;
  logic [19:0] req_addr_s  [2];
  logic [7:0]  req_wdata_s [2];
  logic [1:0]  req_write_s;
  logic        grant_sel_s;
  logic        expire_s;
  logic        complete_s;

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_err_r;

  assign expire_s        = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_err = timeout_err_r;
`else
  assign expire_s        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Gather the per-master request inputs into indexable form.
  always_comb begin
    req_s[0]       = bus.m0_read | bus.m0_write;
    req_s[1]       = bus.m1_read | bus.m1_write;
    req_addr_s[0]  = bus.m0_address;
    req_addr_s[1]  = bus.m1_address;
    req_wdata_s[0] = bus.m0_wdata;
    req_wdata_s[1] = bus.m1_wdata;
    req_write_s[0] = bus.m0_write;
    req_write_s[1] = bus.m1_write;
  end

  // Round-robin choice: a lone pending master wins, a tie goes to the one not served last.
  always_comb begin
    grant_sel_s = 1'b0;
    if (pend_r[0] && pend_r[1]) begin
      grant_sel_s = ~last_r;
    end else if (pend_r[0]) begin
      grant_sel_s = 1'b0;
    end else begin
      grant_sel_s = 1'b1;
    end
  end

  // The granted transaction finishes on a slave ack or a watchdog expiry in WAIT.
  always_comb begin
    complete_s = (state_r == WAIT) && (bus.io_ack || expire_s);
  end

  // Capture master strobes into free pending entries; release the served entry on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r       <= 2'b00;
      pend_write_r <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        pend_addr_r[n]  <= 20'h00000;
        pend_wdata_r[n] <= 8'h00;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (complete_s && (grant_r == 1'(n))) begin
          pend_r[n] <= 1'b0;
        end else if (!pend_r[n] && req_s[n]) begin
          pend_r[n]       <= 1'b1;
          pend_addr_r[n]  <= req_addr_s[n];
          pend_wdata_r[n] <= req_wdata_s[n];
          pend_write_r[n] <= req_write_s[n];
        end else begin
          pend_r[n] <= pend_r[n];
        end
      end
    end
  end

  // Arbitration FSM with registered slave strobes, master acks and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_r       <= 1'b1;
      io_read_r    <= 1'b0;
      io_write_r   <= 1'b0;
      io_address_r <= 20'h00000;
      io_wdata_r   <= 8'h00;
      ack_r        <= 2'b00;
      rdata_r[0]   <= 8'h00;
      rdata_r[1]   <= 8'h00;
`ifdef IO_ARB_TIMEOUT_EN
      cnt_r         <= '0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      ack_r      <= 2'b00;
      io_read_r  <= 1'b0;
      io_write_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|pend_r) begin
            grant_r      <= grant_sel_s;
            io_address_r <= pend_addr_r[grant_sel_s];
            io_wdata_r   <= pend_wdata_r[grant_sel_s];
            io_read_r    <= ~pend_write_r[grant_sel_s];
            io_write_r   <= pend_write_r[grant_sel_s];
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // io_ack during the strobe cycle is deliberately not looked at.
          state_r <= WAIT;
`ifdef IO_ARB_TIMEOUT_EN
          cnt_r   <= '0;
`endif
        end
        WAIT: begin
          if (bus.io_ack) begin
            ack_r[grant_r] <= 1'b1;
            if (!pend_write_r[grant_r]) begin
              rdata_r[grant_r] <= bus.io_rdata;
            end
            last_r  <= grant_r;
            state_r <= IDLE;
          end else if (expire_s) begin
            ack_r[grant_r] <= 1'b1;
            if (!pend_write_r[grant_r]) begin
              rdata_r[grant_r] <= 8'hFF;
            end
`ifdef IO_ARB_TIMEOUT_EN
            timeout_err_r <= 1'b1;
`endif
            last_r  <= grant_r;
            state_r <= IDLE;
          end else begin
`ifdef IO_ARB_TIMEOUT_EN
            cnt_r   <= cnt_r + CNT_W'(1);
`endif
            state_r <= WAIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.io_read    = io_read_r;
  assign bus.io_write   = io_write_r;
  assign bus.io_address = io_address_r;
  assign bus.io_wdata   = io_wdata_r;
  assign bus.m0_ack     = ack_r[0];
  assign bus.m1_ack     = ack_r[1];
  assign bus.m0_rdata   = rdata_r[0];
  assign bus.m1_rdata   = rdata_r[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized
// master traffic and slave response delays, checked every cycle against a
// transaction-level model (pending requests, round-robin order, timing rules).
module tb_io_bus_arbiter;
  localparam int TO = 4;
`ifdef IO_ARB_TIMEOUT_EN
  localparam int MAXD = 6;
`else
  localparam int MAXD = 5;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  io_bus_arbiter_if bus();
  io_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // stimulus for the next cycle
  bit          s_rd [2];
  bit          s_wr [2];
  logic [19:0] s_addr [2];
  logic [7:0]  s_wd [2];
  bit          s_reset;
  bit          force_ack;
  int          fixed_d;
  int          fixed_rdata;

  // reference model
  bit          pend [2];
  logic [19:0] p_addr [2];
  logic [7:0]  p_wd [2];
  bit          p_wr [2];
  int          svc;
  bit          last;
  logic [7:0]  m_rd [2];
  bit          te;
  bit          want_strobe;
  int          want_grant;
  int          w;
  int          ack_d;
  int          n_strobe;
  int          n_ack [2];
  int          strobe_cyc;
  bit          strobe_wr;
  logic [7:0]  strobe_wd;
  logic [19:0] strobe_addr;
  int          req_cyc;
  int          grant_log [$];

  task automatic model_reset();
    pend = '{1'b0, 1'b0};
    svc = -1;
    last = 1'b1;
    m_rd = '{8'h00, 8'h00};
    te = 1'b0;
    want_strobe = 1'b0;
    want_grant = 0;
    w = 0;
  endtask

  task automatic step();
    bit d_rd [2];
    bit d_wr [2];
    logic [19:0] d_addr [2];
    logic [7:0] d_wd [2];
    bit d_ack;
    bit d_reset;
    logic [7:0] d_rdata;
    int d_w;
    bit exp_ack [2];
    bit strobe;
    int g;
    d_reset = s_reset;
    reset = s_reset;
    bus.m0_read = s_rd[0];  bus.m0_write = s_wr[0];
    bus.m0_address = s_addr[0]; bus.m0_wdata = s_wd[0];
    bus.m1_read = s_rd[1];  bus.m1_write = s_wr[1];
    bus.m1_address = s_addr[1]; bus.m1_wdata = s_wd[1];
    if (s_rd[0] || s_wr[0] || s_rd[1] || s_wr[1]) req_cyc = cyc;
    d_rd = s_rd; d_wr = s_wr; d_addr = s_addr; d_wd = s_wd;
    d_w = w;
    if (force_ack) d_ack = 1'b1;
    else if (svc >= 0) d_ack = (w == 0) ? ($urandom_range(3) == 0) : (w == ack_d);
    else d_ack = ($urandom_range(7) == 0);
    d_rdata = (fixed_rdata >= 0) ? 8'(fixed_rdata) : 8'($urandom);
    bus.io_ack = d_ack;
    bus.io_rdata = d_rdata;
    s_rd = '{1'b0, 1'b0};
    s_wr = '{1'b0, 1'b0};
    force_ack = 1'b0;

    @(posedge clock);
    #1;
    cyc++;

    if (d_reset) begin
      model_reset();
      check_eq("rst_io_read", bus.io_read, 1'b0);
      check_eq("rst_io_write", bus.io_write, 1'b0);
      check_eq("rst_io_address", bus.io_address, 20'h00000);
      check_eq("rst_io_wdata", bus.io_wdata, 8'h00);
      check_eq("rst_m0_ack", bus.m0_ack, 1'b0);
      check_eq("rst_m1_ack", bus.m1_ack, 1'b0);
      check_eq("rst_m0_rdata", bus.m0_rdata, 8'h00);
      check_eq("rst_m1_rdata", bus.m1_rdata, 8'h00);
      check_eq("rst_timeout_err", bus.timeout_err, 1'b0);
      return;
    end

    exp_ack = '{1'b0, 1'b0};
    if (svc >= 0 && d_w >= 1) begin
      if (d_ack) begin
        exp_ack[svc] = 1'b1;
        if (!p_wr[svc]) m_rd[svc] = d_rdata;
      end
`ifdef IO_ARB_TIMEOUT_EN
      else if (d_w == TO) begin
        exp_ack[svc] = 1'b1;
        te = 1'b1;
        if (!p_wr[svc]) m_rd[svc] = 8'hFF;
      end
`endif
    end

    // strobes of the previous cycle are seen before that cycle's completion frees an entry
    for (int n = 0; n < 2; n++) begin
      if ((d_rd[n] || d_wr[n]) && !pend[n]) begin
        pend[n] = 1'b1;
        p_addr[n] = d_addr[n];
        p_wd[n] = d_wd[n];
        p_wr[n] = d_wr[n];
      end
    end

    if (exp_ack[0] || exp_ack[1]) begin
      pend[svc] = 1'b0;
      last = svc[0];
      n_ack[svc]++;
      svc = -1;
    end else if (svc >= 0) begin
      w++;
    end

    check_eq("m0_ack", bus.m0_ack, exp_ack[0]);
    check_eq("m1_ack", bus.m1_ack, exp_ack[1]);
    check_eq("m0_rdata", bus.m0_rdata, m_rd[0]);
    check_eq("m1_rdata", bus.m1_rdata, m_rd[1]);
    check_eq("timeout_err", bus.timeout_err, te);

    strobe = bus.io_read | bus.io_write;
    check_eq("io_strobe", strobe, want_strobe);
    if (want_strobe && strobe) begin
      g = want_grant;
      check_eq("io_read", bus.io_read, !p_wr[g]);
      check_eq("io_write", bus.io_write, p_wr[g]);
      check_eq("io_address", bus.io_address, p_addr[g]);
      check_eq("io_wdata", bus.io_wdata, p_wd[g]);
      svc = g;
      w = 0;
      n_strobe++;
      strobe_cyc = cyc;
      strobe_wr = p_wr[g];
      strobe_wd = bus.io_wdata;
      strobe_addr = bus.io_address;
      grant_log.push_back(g);
      ack_d = (fixed_d > 0) ? fixed_d : $urandom_range(MAXD, 1);
    end else if (svc >= 0) begin
      check_eq("io_address_hold", bus.io_address, p_addr[svc]);
      check_eq("io_wdata_hold", bus.io_wdata, p_wd[svc]);
    end

    want_strobe = (svc < 0) && (pend[0] || pend[1]);
    want_grant = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[0] ? 0 : 1);
  endtask

  task automatic drain();
    int k;
    bit busy;
    k = 0;
    busy = (svc >= 0) || pend[0] || pend[1];
    while (busy && k < 300) begin
      step();
      k++;
      busy = (svc >= 0) || pend[0] || pend[1];
    end
    check_eq("drain_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    s_reset = 1'b1;
    step();
    s_reset = 1'b0;
  endtask

  task automatic request(input int m, input bit rd, input bit wr,
                         input logic [19:0] a, input logic [7:0] d);
    s_rd[m] = rd;
    s_wr[m] = wr;
    s_addr[m] = a;
    s_wd[m] = d;
  endtask

  int a0, a1, st0;
  int gsz;
  int k;

  initial begin
    s_rd = '{1'b0, 1'b0};
    s_wr = '{1'b0, 1'b0};
    s_addr = '{20'h0, 20'h0};
    s_wd = '{8'h0, 8'h0};
    s_reset = 1'b0;
    force_ack = 1'b0;
    fixed_d = 0;
    fixed_rdata = -1;
    n_strobe = 0;
    n_ack = '{0, 0};
    strobe_cyc = 0;
    req_cyc = 0;
    model_reset();

    do_reset();
    do_reset();

    // m0 read of 0x12345, slave answers 0xA5 three cycles after io_read
    fixed_d = 3;
    fixed_rdata = 8'hA5;
    a1 = n_ack[1];
    request(0, 1'b1, 1'b0, 20'h12345, 8'h00);
    step();
    drain();
    check_eq("t033_latency", 32'(strobe_cyc - req_cyc), 32'd2);
    check_eq("t033_addr", strobe_addr, 20'h12345);
    check_eq("t033_rdata", bus.m0_rdata, 8'hA5);
    check_eq("t033_m1_acks", 32'(n_ack[1] - a1), 32'd0);
    fixed_rdata = -1;
    fixed_d = 0;

    // simultaneous writes after reset, then a lone m0, then another pair
    do_reset();
    request(0, 1'b0, 1'b1, 20'h00100, 8'h11);
    request(1, 1'b0, 1'b1, 20'h00200, 8'h22);
    step();
    drain();
    gsz = grant_log.size();
    check_eq("t034_first", grant_log[gsz-2], 32'd0);
    check_eq("t034_second", grant_log[gsz-1], 32'd1);
    request(0, 1'b1, 1'b0, 20'h00300, 8'h00);
    step();
    drain();
    request(0, 1'b0, 1'b1, 20'h00400, 8'h33);
    request(1, 1'b0, 1'b1, 20'h00500, 8'h44);
    step();
    drain();
    gsz = grant_log.size();
    check_eq("t034_rr_first", grant_log[gsz-2], 32'd1);
    check_eq("t034_rr_second", grant_log[gsz-1], 32'd0);

    // m1 read to load m1_rdata, then write-with-read must be a write
    fixed_rdata = 8'h77;
    request(1, 1'b1, 1'b0, 20'h00020, 8'h00);
    step();
    drain();
    fixed_rdata = -1;
    request(1, 1'b1, 1'b1, 20'h00010, 8'h3C);
    step();
    drain();
    check_eq("t035_is_write", strobe_wr, 1'b1);
    check_eq("t035_wdata", strobe_wd, 8'h3C);
    check_eq("t035_m1_rdata", bus.m1_rdata, 8'h77);

    // repeated m0 strobes while its request is outstanding
    fixed_d = 4;
    st0 = n_strobe;
    a0 = n_ack[0];
    request(0, 1'b1, 1'b0, 20'h0ABCD, 8'h00);
    step();
    request(0, 1'b1, 1'b0, 20'h0DEAD, 8'h00);
    step();
    step();
    request(0, 1'b0, 1'b1, 20'h0BEEF, 8'h55);
    step();
    drain();
    check_eq("t038_strobes", 32'(n_strobe - st0), 32'd1);
    check_eq("t038_acks", 32'(n_ack[0] - a0), 32'd1);

    // reset while waiting for the slave, followed by a late io_ack
    fixed_d = 1000;
    a0 = n_ack[0];
    request(0, 1'b1, 1'b0, 20'h00042, 8'h00);
    step();
    k = 0;
    while (!(svc >= 0 && w == 2) && k < 20) begin
      step();
      k++;
    end
    check_eq("t036_reached_wait", (svc >= 0 && w == 2), 1'b1);
    do_reset();
    force_ack = 1'b1;
    step();
    step();
    step();
    check_eq("t036_no_ack", 32'(n_ack[0] - a0), 32'd0);
    fixed_d = 0;
    request(0, 1'b1, 1'b0, 20'h00043, 8'h00);
    step();
    drain();
    check_eq("t036_recover", 32'(n_ack[0] - a0), 32'd1);

`ifdef IO_ARB_TIMEOUT_EN
    // silent slave: watchdog acks with 0xFF and raises the sticky flag
    fixed_d = 1000;
    request(0, 1'b1, 1'b0, 20'h00777, 8'h00);
    step();
    drain();
    check_eq("t037_latency", 32'(cyc - strobe_cyc), 32'(TO + 1));
    check_eq("t037_rdata", bus.m0_rdata, 8'hFF);
    repeat (5) step();
    check_eq("t037_sticky", bus.timeout_err, 1'b1);
    fixed_d = 0;
    do_reset();
`else
    // silent slave: WAIT persists, no ack and no error flag
    fixed_d = 1000;
    a0 = n_ack[0];
    request(0, 1'b1, 1'b0, 20'h00777, 8'h00);
    step();
    repeat (300) step();
    check_eq("t031_no_ack", 32'(n_ack[0] - a0), 32'd0);
    check_eq("t031_no_err", bus.timeout_err, 1'b0);
    fixed_d = 0;
    do_reset();
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(3) == 0) begin
          bit rd, wr;
          rd = 1'($urandom);
          wr = 1'($urandom);
          if (!rd && !wr) rd = 1'b1;
          request(m, rd, wr, 20'($urandom), 8'($urandom));
        end
      end
      s_reset = ($urandom_range(399) == 0);
      step();
      s_reset = 1'b0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
